// File: rtl/sr_cfg_serializer_pkg.sv
// Shared definitions for the shift-register configuration path: default
// chain geometry, FSM state encodings and a small select-decoding helper.
package sr_cfg_serializer_pkg;

  // Default chain geometry and shift-clock divider.
  localparam int SIZESRSTAT_DEF  = 88;
  localparam int SIZESRDYN_DEF   = 16;
  localparam int SIZEADDRMUX_DEF = 7;
  localparam int CLKDIV_DEF      = 2;

  // Serializer FSM state encodings (plain constants so older tools and the
  // upstream fsm block can share them unchanged).
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_HI    = 3'd2;
  localparam logic [2:0] ST_LO    = 3'd3;
  localparam logic [2:0] ST_LATCH = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  // A transfer is legal only when exactly one chain is selected.
  function automatic logic sel_onehot(input logic sel_stat, input logic sel_dyn);
    return sel_stat ^ sel_dyn;
  endfunction

endpackage

// File: rtl/sr_cfg_serializer_bit_mux.sv
// Combinational bit selector: picks one bit of the shadow word by index.
// Indices beyond the word width return 0. The parent registers the result.
module sr_bit_mux
  import sr_cfg_serializer_pkg::*;
#(
  parameter int WIDTH = SIZESRSTAT_DEF,
  parameter int ADDRW = SIZEADDRMUX_DEF
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [ADDRW-1:0] idx_i,
  output logic             bit_o
);

  // Compare the index against every bit position; at most one matches.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    bit_o = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (idx_i == ADDRW'(i)) begin
        bit_o = data_i[i];
      end
    end
  end

endmodule

// File: rtl/sr_cfg_serializer.sv
// Serializes a captured configuration word, MSB first, into either the
// static or the dynamic chip configuration shift register. Generates a
// divided shift clock with data, then a one-cycle load strobe for the
// selected chain and a done pulse. All outputs are registered from the
// current FSM state, so each output trails its state by one cycle.
module sr_cfg_serializer
  import sr_cfg_serializer_pkg::*;
#(
  parameter int SIZESRSTAT  = SIZESRSTAT_DEF,
  parameter int SIZESRDYN   = SIZESRDYN_DEF,
  parameter int SIZEADDRMUX = SIZEADDRMUX_DEF,
  parameter int CLKDIV      = CLKDIV_DEF
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  start,
  input  logic                  sel_stat,
  input  logic                  sel_dyn,
  input  logic [SIZESRSTAT-1:0] cfg_stat,
  input  logic [SIZESRDYN-1:0]  cfg_dyn,
  output logic                  sr_clk,
  output logic                  sr_din,
  output logic                  sr_load_stat,
  output logic                  sr_load_dyn,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  // Phase divider: counts 0..CLKDIV-1 within each HI or LO phase.
  localparam int                     DIVW     = $clog2(CLKDIV) + 1;
  localparam logic [DIVW-1:0]        DIV_LAST = DIVW'(CLKDIV - 1);
  // Starting bit index for each chain (MSB of the chain).
  localparam logic [SIZEADDRMUX-1:0] IDX_STAT = SIZEADDRMUX'(SIZESRSTAT - 1);
  localparam logic [SIZEADDRMUX-1:0] IDX_DYN  = SIZEADDRMUX'(SIZESRDYN - 1);

  // Control state.
  logic [2:0]             state_q,  state_d;
  logic [DIVW-1:0]        div_q,    div_d;
  logic [SIZEADDRMUX-1:0] idx_q,    idx_d;
  logic                   last_q,   last_d;     // bit 0 has had its HI phase
  logic [SIZESRSTAT-1:0]  shadow_q, shadow_d;   // captured, zero-extended word
  logic                   is_stat_q, is_stat_d; // captured chain select

  // Registered outputs.
  logic sr_clk_q,       sr_clk_d;
  logic sr_din_q,       sr_din_d;
  logic sr_load_stat_q, sr_load_stat_d;
  logic sr_load_dyn_q,  sr_load_dyn_d;
  logic busy_q,         busy_d;
  logic done_q,         done_d;
  logic err_q,          err_d;

  logic phase_end;
  logic mux_bit;

  assign phase_end = (div_q == DIV_LAST);

  // Current data bit of the shadow word, selected by the index counter.
  sr_bit_mux #(
    .WIDTH (SIZESRSTAT),
    .ADDRW (SIZEADDRMUX)
  ) u_bit_mux (
    .data_i (shadow_q),
    .idx_i  (idx_q),
    .bit_o  (mux_bit)
  );

  // Next-state logic: transfer sequencing, phase divider and bit index.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    idx_d     = idx_q;
    last_d    = last_q;
    shadow_d  = shadow_q;
    is_stat_d = is_stat_q;

    case (state_q)
      ST_IDLE: begin
        div_d  = '0;
        last_d = 1'b0;
        if (start && sel_onehot(sel_stat, sel_dyn)) begin
          is_stat_d = sel_stat;
          if (sel_stat) begin
            shadow_d = cfg_stat;
            idx_d    = IDX_STAT;
          end else begin
            shadow_d = SIZESRSTAT'(cfg_dyn);
            idx_d    = IDX_DYN;
          end
          state_d = ST_SETUP;
        end
      end

      ST_SETUP: begin
        div_d   = '0;
        state_d = ST_HI;
      end

      // Clock high: data held. On leaving, step to the next bit; once bit 0
      // has been clocked the index stays at 0 and the final flag is set.
      ST_HI: begin
        if (phase_end) begin
          div_d   = '0;
          state_d = ST_LO;
          if (idx_q != '0) begin
            idx_d = idx_q - 1'b1;
          end else begin
            last_d = 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      // Clock low: next bit presented. Loop back unless bit 0 was just sent.
      ST_LO: begin
        if (phase_end) begin
          div_d   = '0;
          state_d = last_q ? ST_LATCH : ST_HI;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      ST_LATCH: state_d = ST_DONE;

      ST_DONE:  state_d = ST_IDLE;

      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode from the current state; registered below.
  always_comb begin
    sr_clk_d       = (state_q == ST_HI);
    sr_din_d       = (state_q == ST_SETUP || state_q == ST_HI || state_q == ST_LO) ?
                     mux_bit : 1'b0;
    sr_load_stat_d = (state_q == ST_LATCH) &&  is_stat_q;
    sr_load_dyn_d  = (state_q == ST_LATCH) && !is_stat_q;
    busy_d         = (state_q != ST_IDLE);
    done_d         = (state_q == ST_DONE);
    err_d          = (state_q == ST_IDLE) && start && !sel_onehot(sel_stat, sel_dyn);
  end

  // State and output registers; reset aborts any transfer immediately.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q        <= ST_IDLE;
      div_q          <= '0;
      idx_q          <= '0;
      last_q         <= 1'b0;
      shadow_q       <= '0;
      is_stat_q      <= 1'b0;
      sr_clk_q       <= 1'b0;
      sr_din_q       <= 1'b0;
      sr_load_stat_q <= 1'b0;
      sr_load_dyn_q  <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q        <= state_d;
      div_q          <= div_d;
      idx_q          <= idx_d;
      last_q         <= last_d;
      shadow_q       <= shadow_d;
      is_stat_q      <= is_stat_d;
      sr_clk_q       <= sr_clk_d;
      sr_din_q       <= sr_din_d;
      sr_load_stat_q <= sr_load_stat_d;
      sr_load_dyn_q  <= sr_load_dyn_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      err_q          <= err_d;
    end
  end

  assign sr_clk       = sr_clk_q;
  assign sr_din       = sr_din_q;
  assign sr_load_stat = sr_load_stat_q;
  assign sr_load_dyn  = sr_load_dyn_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_sr_cfg_serializer.sv
// Scoreboard bench for sr_cfg_serializer: stimulus pushes expected transfers
// and error pulses; a negedge monitor checks every shifted bit, load strobe,
// done timing and error pulse against them.
module tb_sr_cfg_serializer;

  localparam int SS = 88;
  localparam int SD = 16;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          start = 1'b0;
  logic          sel_stat = 1'b0;
  logic          sel_dyn = 1'b0;
  logic [SS-1:0] cfg_stat = '0;
  logic [SD-1:0] cfg_dyn = '0;
  logic          sr_clk, sr_din, sr_load_stat, sr_load_dyn, busy, done, err;

  sr_cfg_serializer #(
    .SIZESRSTAT  (SS),
    .SIZESRDYN   (SD),
    .SIZEADDRMUX (7),
    .CLKDIV      (2)
  ) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .start        (start),
    .sel_stat     (sel_stat),
    .sel_dyn      (sel_dyn),
    .cfg_stat     (cfg_stat),
    .cfg_dyn      (cfg_dyn),
    .sr_clk       (sr_clk),
    .sr_din       (sr_din),
    .sr_load_stat (sr_load_stat),
    .sr_load_dyn  (sr_load_dyn),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    bit          is_stat;
    int          size;
    logic [87:0] word;
    int          done_cyc;
  } xfer_t;

  xfer_t       exp_q[$];
  int          exp_err = 0;
  int          checks = 0;
  int          errors = 0;
  int          rise_cnt = 0;
  int          load_cnt = 0;
  int          done_cnt = 0;
  logic [87:0] obs_word = '0;
  logic        prev_clk = 1'b0;

  task automatic check(input string name, input logic [87:0] act, input logic [87:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares DUT activity against the scoreboard queues.
  always @(negedge CLK) begin
    xfer_t x;
    if (!RST_N) begin
      rise_cnt = 0;
      load_cnt = 0;
      obs_word = '0;
      prev_clk = 1'b0;
    end else begin
      if (exp_q.size() == 0) begin
        check("idle_busy", busy, 0);
        check("idle_sr_clk", sr_clk, 0);
      end
      if (sr_clk && !prev_clk) begin
        if (exp_q.size() == 0) check("rise_unexpected", 1, 0);
        else if (rise_cnt >= exp_q[0].size) check("rise_extra", rise_cnt, exp_q[0].size - 1);
        else check("sr_din_bit", sr_din, exp_q[0].word[exp_q[0].size - 1 - rise_cnt]);
        obs_word = {obs_word[86:0], sr_din};
        rise_cnt++;
      end
      prev_clk = sr_clk;
      if (sr_load_stat || sr_load_dyn) begin
        if (exp_q.size() == 0) check("load_unexpected", 1, 0);
        else begin
          check("load_stat", sr_load_stat, exp_q[0].is_stat);
          check("load_dyn", sr_load_dyn, !exp_q[0].is_stat);
          load_cnt++;
        end
      end
      if (err) begin
        check("err_expected", exp_err > 0, 1);
        if (exp_err > 0) exp_err--;
      end
      if (done) begin
        if (exp_q.size() == 0) check("done_unexpected", 1, 0);
        else begin
          x = exp_q.pop_front();
          check("done_cycle", cyc, x.done_cyc);
          check("rise_count", rise_cnt, x.size);
          check("load_count", load_cnt, 1);
          check("shifted_word", obs_word, x.word);
          done_cnt++;
          rise_cnt = 0;
          load_cnt = 0;
          obs_word = '0;
        end
      end
    end
  end

  // Legal transfer request; latency 67 (dyn) or 355 (stat) cycles to done.
  task automatic issue(input bit stat, input logic [87:0] word);
    @(negedge CLK);
    sel_stat = stat;
    sel_dyn  = !stat;
    if (stat) cfg_stat = word;
    else      cfg_dyn  = word[15:0];
    start = 1'b1;
    exp_q.push_back('{is_stat: stat, size: stat ? 88 : 16, word: word,
                      done_cyc: cyc + 1 + (stat ? 355 : 67)});
    @(negedge CLK);
    start    = 1'b0;
    sel_stat = 1'b0;
    sel_dyn  = 1'b0;
    cfg_stat = ~cfg_stat;
    cfg_dyn  = ~cfg_dyn;
  endtask

  // Illegal select: expect one err pulse and no transfer.
  task automatic issue_bad(input bit s, input bit d);
    @(negedge CLK);
    sel_stat = s;
    sel_dyn  = d;
    start    = 1'b1;
    exp_err++;
    @(negedge CLK);
    start    = 1'b0;
    sel_stat = 1'b0;
    sel_dyn  = 1'b0;
    repeat (4) @(negedge CLK);
    check("err_drained", exp_err, 0);
    check("err_no_busy", busy, 0);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic wait_rise(input int k, input int budget);
    int n = 0;
    while (rise_cnt < k && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check("rise_wait", rise_cnt >= k, 1);
  endtask

  function automatic logic [6:0] outs();
    return {sr_clk, sr_din, sr_load_stat, sr_load_dyn, busy, done, err};
  endfunction

  initial begin
    int d0;
    int n;

    // Reset state.
    #12;
    check("reset_outputs", outs(), 7'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);

    // 1: dynamic chain, 16'hA5C3.
    issue(1'b0, 88'hA5C3);
    wait_drain(200);

    // 2: static chain, MSB and LSB set.
    issue(1'b1, 88'h80_0000_0000_0000_0000_0001);
    wait_drain(500);

    // 3: both selects, then neither.
    issue_bad(1'b1, 1'b1);
    issue_bad(1'b0, 1'b0);

    // 4: start with static select mid-transfer is ignored.
    issue(1'b0, 88'h5A3C);
    wait_rise(5, 100);
    @(negedge CLK);
    sel_stat = 1'b1;
    cfg_stat = '1;
    cfg_dyn  = 16'hFFFF;
    start    = 1'b1;
    @(negedge CLK);
    start    = 1'b0;
    sel_stat = 1'b0;
    wait_drain(200);
    repeat (10) @(negedge CLK);

    // 5: reset after the 8th shift clock rise aborts the transfer.
    issue(1'b0, 88'hC0DE);
    wait_rise(8, 100);
    #2 RST_N = 1'b0;
    #1 check("abort_outputs", outs(), 7'd0);
    exp_q.delete();
    repeat (3) begin
      @(negedge CLK);
      check("abort_hold", outs(), 7'd0);
    end
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    issue(1'b0, 88'h3C96);
    wait_drain(200);

    // 6: back-to-back transfers.
    d0 = done_cnt;
    issue(1'b0, 88'h1234);
    n = 0;
    while (!done && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check("b2b_first_done", done, 1);
    issue(1'b0, 88'hBEEF);
    wait_drain(200);
    check("b2b_done_count", done_cnt - d0, 2);

    repeat (5) @(negedge CLK);
    check("final_idle", outs(), 7'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
